// File: rtl/s2p_pkg.sv
// Purpose: shared types and default constants for the serial link (transmitter side and receiver top).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: tx_state_t (transmitter FSM states), S2P_BITS / S2P_HALF defaults.
package s2p_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    GAP      = 2'd3
  } tx_state_t;

  // Defaults shared with the 4-bit receiver so both ends agree on frame shape.
  localparam int S2P_BITS = 4;
  localparam int S2P_HALF = 2;

endpackage

// File: rtl/sclk_phase_gen.sv
// Purpose: phase counter that paces each sclk half-period of the transmitter.
// Latency: phase_end asserts combinationally on the HALF-th cycle of a phase.
// Backpressure: none; it counts whenever run is high.
// Ports: clk, rst_n; run (frame active); phase_end (last cycle of a phase);
//        phase_penult (second-to-last cycle of a phase, only when HALF >= 2).
module sclk_phase_gen #(
  parameter int HALF = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic phase_end,
  output logic phase_penult
);

  localparam int PW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PW-1:0] LAST   = PW'(HALF - 1);
  localparam logic [PW-1:0] PENULT = PW'((HALF >= 2) ? HALF - 2 : 0);

  logic [PW-1:0] count;

  assign phase_end    = run && (count == LAST);
  // Lets the FSM register a pulse that lands on the final cycle of a phase.
  assign phase_penult = run && (HALF >= 2) && (count == PENULT);

  // Every state change happens on phase_end, so wrapping here restarts the
  // count for the new state; idle holds it at 0 so a frame starts at phase 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!run || phase_end) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/parallel_to_serial_tx.sv
// Purpose: accepts a BITS-wide word on valid/ready and shifts it out with a generated sclk.
// Latency: first bit on serial_out one cycle after acceptance; frame period 2*BITS*HALF+HALF+1 cycles.
// Backpressure: in_ready is low for the whole frame; the sender holds its word until idle.
// Ports: clk, rst_n; in_data/in_valid/in_ready (word input handshake);
//        serial_out, sclk (to the receiver); busy (frame in progress); done (last-cycle pulse).
module parallel_to_serial_tx
  import s2p_pkg::*;
#(
  parameter int BITS      = S2P_BITS,
  parameter int HALF      = S2P_HALF,
  parameter int MSB_FIRST = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [BITS-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            serial_out,
  output logic            sclk,
  output logic            busy,
  output logic            done
);

  localparam int BW = $clog2(BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(BITS - 1);

  tx_state_t       state;
  logic [BW-1:0]   bit_cnt;
  logic [BITS-1:0] sreg;
  logic            phase_end;
  logic            phase_penult;
  logic            first_bit;
  logic            next_bit;
  logic [BITS-1:0] sreg_shifted;

  sclk_phase_gen #(.HALF(HALF)) u_phase (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (state != IDLE),
    .phase_end    (phase_end),
    .phase_penult (phase_penult)
  );

  // Ready is held low while reset is asserted.
  assign in_ready = rst_n && (state == IDLE);

  // next_bit is the bit that lands at the head of the register after one shift.
  always_comb begin
    first_bit    = 1'b0;
    next_bit     = 1'b0;
    sreg_shifted = '0;
    if (MSB_FIRST != 0) begin
      first_bit    = in_data[BITS-1];
      next_bit     = sreg[BITS-2];
      sreg_shifted = {sreg[BITS-2:0], 1'b0};
    end else begin
      first_bit    = in_data[0];
      next_bit     = sreg[1];
      sreg_shifted = {1'b0, sreg[BITS-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      sreg       <= '0;
      serial_out <= 1'b0;
      sclk       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            state      <= SHIFT_LO;
            sreg       <= in_data;
            serial_out <= first_bit;
            sclk       <= 1'b0;
            busy       <= 1'b1;
            bit_cnt    <= '0;
          end
        end
        SHIFT_LO: begin
          if (phase_end) begin
            state <= SHIFT_HI;
            sclk  <= 1'b1;
          end
        end
        SHIFT_HI: begin
          if (phase_end) begin
            sclk <= 1'b0;
            if (bit_cnt == LAST_BIT) begin
              state      <= GAP;
              serial_out <= 1'b0;
              // A one-cycle gap is itself the final cycle of the frame.
              done       <= (HALF == 1);
            end else begin
              state      <= SHIFT_LO;
              bit_cnt    <= bit_cnt + 1'b1;
              sreg       <= sreg_shifted;
              serial_out <= next_bit;
            end
          end
        end
        GAP: begin
          if (phase_penult) begin
            done <= 1'b1;
          end
          if (phase_end) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_to_serial_tx.sv
// Purpose: directed bench for parallel_to_serial_tx with a 4-bit MSB-first receiver model per instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_parallel_to_serial_tx;

  logic clk;
  logic rst_n;

  // Default instance (BITS=4, HALF=2, MSB first)
  logic [3:0] d_dat;
  logic d_vld, d_rdy, d_so, d_sclk, d_busy, d_done;
  // LSB-first instance
  logic [3:0] l_dat;
  logic l_vld, l_rdy, l_so, l_sclk, l_busy, l_done;
  // Small corner instance (BITS=2, HALF=1)
  logic [1:0] s_dat;
  logic s_vld, s_rdy, s_so, s_sclk, s_busy, s_done;

  logic [3:0] rx_d, rx_l, rx_s;

  int checks;
  int errors;

  logic [63:0] d_so_h, d_sclk_h, d_done_h, d_busy_h, d_rdy_h;
  logic [63:0] l_so_h, s_so_h, s_sclk_h, s_done_h, s_rdy_h;
  logic [3:0]  rx_d_h [0:63];

  parallel_to_serial_tx u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(d_dat), .in_valid(d_vld), .in_ready(d_rdy),
    .serial_out(d_so), .sclk(d_sclk), .busy(d_busy), .done(d_done)
  );

  parallel_to_serial_tx #(.BITS(4), .HALF(2), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(l_dat), .in_valid(l_vld), .in_ready(l_rdy),
    .serial_out(l_so), .sclk(l_sclk), .busy(l_busy), .done(l_done)
  );

  parallel_to_serial_tx #(.BITS(2), .HALF(1), .MSB_FIRST(1)) u_small (
    .clk(clk), .rst_n(rst_n), .in_data(s_dat), .in_valid(s_vld), .in_ready(s_rdy),
    .serial_out(s_so), .sclk(s_sclk), .busy(s_busy), .done(s_done)
  );

  // Receiver models: sample serial data on each sclk rising edge, MSB first.
  always @(posedge d_sclk or negedge rst_n)
    if (!rst_n) rx_d <= 4'h0; else rx_d <= {rx_d[2:0], d_so};
  always @(posedge l_sclk or negedge rst_n)
    if (!rst_n) rx_l <= 4'h0; else rx_l <= {rx_l[2:0], l_so};
  always @(posedge s_sclk or negedge rst_n)
    if (!rst_n) rx_s <= 4'h0; else rx_s <= {rx_s[2:0], s_so};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample every instance on the falling edge; index c is the cycle number
  // counted from the acceptance edge (cycle 1 is the first after acceptance).
  task automatic tick(input int c);
    @(negedge clk);
    d_so_h[c] = d_so;   d_sclk_h[c] = d_sclk; d_done_h[c] = d_done;
    d_busy_h[c] = d_busy; d_rdy_h[c] = d_rdy; rx_d_h[c] = rx_d;
    l_so_h[c] = l_so;
    s_so_h[c] = s_so;   s_sclk_h[c] = s_sclk; s_done_h[c] = s_done; s_rdy_h[c] = s_rdy;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    d_dat = '0; d_vld = 1'b0;
    l_dat = '0; l_vld = 1'b0;
    s_dat = '0; s_vld = 1'b0;

    // ---- reset then idle ----
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("idle_rdy_sclk_so_busy", {d_rdy, d_sclk, d_so, d_busy}, 4'b1000);
    end
    chk("idle_done", d_done, 1'b0);
    chk("idle_small_rdy", s_rdy, 1'b1);

    // ---- single word on all three instances ----
    d_dat = 4'b1011; d_vld = 1'b1;
    l_dat = 4'b0001; l_vld = 1'b1;
    s_dat = 2'b10;   s_vld = 1'b1;
    @(posedge clk);
    #1;
    d_vld = 1'b0; l_vld = 1'b0; s_vld = 1'b0;
    d_dat = 4'b0100; l_dat = 4'b1110; s_dat = 2'b01;
    for (int c = 1; c <= 20; c++) tick(c);

    chk("d_c1_so", d_so_h[1], 1'b1);
    chk("d_c1_busy", d_busy_h[1], 1'b1);
    chk("d_c1_rdy", d_rdy_h[1], 1'b0);
    chk("d_so_c3", d_so_h[3], 1'b1);
    chk("d_so_c7", d_so_h[7], 1'b0);
    chk("d_so_c11", d_so_h[11], 1'b1);
    chk("d_so_c15", d_so_h[15], 1'b1);
    for (int c = 1; c <= 16; c++)
      chk("d_sclk_wave", d_sclk_h[c], ((c - 1) % 4) >= 2);
    chk("d_gap_so_sclk", {d_so_h[17], d_sclk_h[17], d_so_h[18], d_sclk_h[18]}, 4'b0000);
    chk("d_done_17_18_19", {d_done_h[17], d_done_h[18], d_done_h[19]}, 3'b010);
    chk("d_busy_18_19", {d_busy_h[18], d_busy_h[19]}, 2'b10);
    chk("d_rdy_18_19", {d_rdy_h[18], d_rdy_h[19]}, 2'b01);
    chk("d_rx_word", rx_d_h[19], 4'b1011);

    chk("l_so_3_7_11_15", {l_so_h[3], l_so_h[7], l_so_h[11], l_so_h[15]}, 4'b1000);
    chk("l_rx_word", rx_l, 4'b1000);

    chk("s_sclk_1to5", {s_sclk_h[1], s_sclk_h[2], s_sclk_h[3], s_sclk_h[4], s_sclk_h[5]}, 5'b01010);
    chk("s_so_2_4", {s_so_h[2], s_so_h[4]}, 2'b10);
    chk("s_done_4_5_6", {s_done_h[4], s_done_h[5], s_done_h[6]}, 3'b010);
    chk("s_rdy_5_6", {s_rdy_h[5], s_rdy_h[6]}, 2'b01);
    chk("s_rx_word", rx_s[1:0], 2'b10);

    // ---- back-to-back with in_valid held high ----
    d_dat = 4'hA; d_vld = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 40; c++) begin
      tick(c);
      if (c == 5)  d_dat = 4'hF;
      if (c == 10) d_dat = 4'h5;
      if (c == 20) d_vld = 1'b0;
    end
    chk("b2b_a_so", {d_so_h[3], d_so_h[7], d_so_h[11], d_so_h[15]}, 4'b1010);
    chk("b2b_rx_a", rx_d_h[19], 4'hA);
    chk("b2b_rdy_19", d_rdy_h[19], 1'b1);
    chk("b2b_c20_busy_rdy_sclk_so", {d_busy_h[20], d_rdy_h[20], d_sclk_h[20], d_so_h[20]}, 4'b1000);
    chk("b2b_5_so", {d_so_h[22], d_so_h[26], d_so_h[30], d_so_h[34]}, 4'b0101);
    chk("b2b_done_37", d_done_h[37], 1'b1);
    chk("b2b_rdy_38", d_rdy_h[38], 1'b1);
    chk("b2b_rx_5", rx_d_h[38], 4'h5);
    chk("b2b_no_third_frame", d_busy_h[40], 1'b0);

    // ---- reset mid-frame ----
    d_dat = 4'hE; d_vld = 1'b1;
    @(posedge clk);
    #1;
    d_vld = 1'b0;
    for (int c = 1; c <= 9; c++) tick(c);
    chk("mid_c9_busy_so", {d_busy_h[9], d_so_h[9]}, 2'b11);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", {d_so, d_sclk, d_busy, d_done}, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_held", {d_so, d_sclk, d_busy, d_done}, 4'b0000);
    rst_n = 1'b1;
    #1;
    chk("mid_rdy_after_release", d_rdy, 1'b1);
    d_dat = 4'h3; d_vld = 1'b1;
    @(posedge clk);
    #1;
    d_vld = 1'b0;
    for (int c = 1; c <= 19; c++) tick(c);
    chk("mid_new_so", {d_so_h[3], d_so_h[7], d_so_h[11], d_so_h[15]}, 4'b0011);
    chk("mid_new_done_18", d_done_h[18], 1'b1);
    chk("mid_new_rdy_19", d_rdy_h[19], 1'b1);
    chk("mid_new_rx", rx_d_h[19], 4'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
